// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential divider.
//   seq_div_state_e    : controller states (IDLE, CALC, FIX, DONE)
//   seq_div_cnt_width  : width of the iteration counter for a given operand width
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } seq_div_state_e;

  // Counter must be able to hold width_p (one more than the last iteration index).
  function automatic int seq_div_cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_add.sv
// One-bit full adder cell.
//   a_i, b_i : addend bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out
module full_add (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/seq_div_ripple_sub.sv
// Ripple-carry subtractor built from full_add cells: diff = a + ~b + 1.
//   a_i, b_i  : minuend and subtrahend (width_p bits)
//   diff_o    : a - b modulo 2^width_p
//   borrow_o  : 1 when a < b (unsigned); with a = 0 it flags b != 0
module ripple_sub #(
  parameter int width_p = 8
) (
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic [width_p-1:0] diff_o,
  output logic               borrow_o
);

  logic [width_p:0] carry;

  // Carry-in of 1 completes the two's-complement of b.
  assign carry[0] = 1'b1;

  for (genvar gi = 0; gi < width_p; gi++) begin : g_bit
    full_add u_fa (
      .a_i (a_i[gi]),
      .b_i (~b_i[gi]),
      .c_i (carry[gi]),
      .s_o (diff_o[gi]),
      .c_o (carry[gi+1])
    );
  end

  assign borrow_o = ~carry[width_p];

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider, signed or unsigned, one quotient bit per cycle.
//   clk_i, reset_i        : clock, synchronous active-high reset
//   valid_i / ready_o     : operand handshake (signed_i, dividend_i, divisor_i)
//   valid_o / ready_i     : result handshake (quotient_o, remainder_o, div_zero_o)
// Latency is width_p+2 cycles regardless of operands; one operation in flight.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               signed_i,
  input  logic [width_p-1:0] dividend_i,
  input  logic [width_p-1:0] divisor_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [width_p-1:0] quotient_o,
  output logic [width_p-1:0] remainder_o,
  output logic               div_zero_o
);

  localparam int cnt_w_lp = seq_div_cnt_width(width_p);
  localparam logic [cnt_w_lp-1:0] last_iter_lp = cnt_w_lp'(width_p - 1);

  seq_div_state_e      state_reg, state_next;
  logic [cnt_w_lp-1:0] cnt_reg, cnt_next;
  logic [width_p-1:0]  quo_reg, quo_next;   // dividend magnitude, shifted out as quotient shifts in
  logic [width_p-1:0]  rem_reg, rem_next;   // partial remainder, then final remainder
  logic [width_p-1:0]  dvs_reg, dvs_next;   // divisor magnitude
  logic                dvd_neg_reg, dvd_neg_next;
  logic                dvs_neg_reg, dvs_neg_next;
  logic                dvz_reg, dvz_next;

  // Trial subtract on width_p+1 bits: {remainder, next dividend bit} - divisor.
  logic [width_p:0] trial_a, trial_diff;
  logic             trial_borrow;
  logic             unused_trial_msb;

  assign trial_a = {rem_reg, quo_reg[width_p-1]};

  ripple_sub #(.width_p(width_p + 1)) u_trial (
    .a_i      (trial_a),
    .b_i      ({1'b0, dvs_reg}),
    .diff_o   (trial_diff),
    .borrow_o (trial_borrow)
  );

  // A successful trial always leaves a value below the divisor, so the MSB is 0.
  assign unused_trial_msb = trial_diff[width_p];

  // Two negators shared in time: in IDLE they produce operand magnitudes,
  // in FIX they apply the sign correction to quotient and remainder.
  logic [width_p-1:0] neg_q_in, neg_q_out, neg_r_in, neg_r_out;
  logic               unused_neg_q_borrow;
  logic               neg_r_borrow;

  assign neg_q_in = (state_reg == FIX) ? quo_reg : dividend_i;
  assign neg_r_in = (state_reg == FIX) ? rem_reg : divisor_i;

  ripple_sub #(.width_p(width_p)) u_neg_q (
    .a_i      ('0),
    .b_i      (neg_q_in),
    .diff_o   (neg_q_out),
    .borrow_o (unused_neg_q_borrow)
  );

  ripple_sub #(.width_p(width_p)) u_neg_r (
    .a_i      ('0),
    .b_i      (neg_r_in),
    .diff_o   (neg_r_out),
    .borrow_o (neg_r_borrow)
  );

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    quo_next     = quo_reg;
    rem_next     = rem_reg;
    dvs_next     = dvs_reg;
    dvd_neg_next = dvd_neg_reg;
    dvs_neg_next = dvs_neg_reg;
    dvz_next     = dvz_reg;

    case (state_reg)
      IDLE: begin
        if (valid_i) begin
          dvd_neg_next = signed_i & dividend_i[width_p-1];
          dvs_neg_next = signed_i & divisor_i[width_p-1];
          quo_next     = dvd_neg_next ? neg_q_out : dividend_i;
          dvs_next     = dvs_neg_next ? neg_r_out : divisor_i;
          // 0 - divisor borrows exactly when the divisor is non-zero.
          dvz_next     = ~neg_r_borrow;
          rem_next     = '0;
          cnt_next     = '0;
          state_next   = CALC;
        end
      end

      CALC: begin
        quo_next = {quo_reg[width_p-2:0], ~trial_borrow};
        rem_next = trial_borrow ? trial_a[width_p-1:0] : trial_diff[width_p-1:0];
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == last_iter_lp) begin
          state_next = FIX;
        end
      end

      FIX: begin
        // A zero divisor already leaves |dividend| as remainder; only the
        // quotient needs forcing so that signed mode also reports all ones.
        if (dvz_reg) begin
          quo_next = '1;
        end else if (dvd_neg_reg ^ dvs_neg_reg) begin
          quo_next = neg_q_out;
        end
        if (dvd_neg_reg) begin
          rem_next = neg_r_out;
        end
        state_next = DONE;
      end

      DONE: begin
        if (ready_i) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      quo_reg     <= '0;
      rem_reg     <= '0;
      dvs_reg     <= '0;
      dvd_neg_reg <= 1'b0;
      dvs_neg_reg <= 1'b0;
      dvz_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      quo_reg     <= quo_next;
      rem_reg     <= rem_next;
      dvs_reg     <= dvs_next;
      dvd_neg_reg <= dvd_neg_next;
      dvs_neg_reg <= dvs_neg_next;
      dvz_reg     <= dvz_next;
    end
  end

  assign ready_o     = (state_reg == IDLE);
  assign valid_o     = (state_reg == DONE);
  assign quotient_o  = quo_reg;
  assign remainder_o = rem_reg;
  assign div_zero_o  = dvz_reg;

endmodule

// File: tb/tb_seq_div.sv
// Directed testbench for seq_div at width_p = 8.
module tb_seq_div;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       valid_i;
  logic       ready_o;
  logic       signed_i;
  logic [7:0] dividend_i;
  logic [7:0] divisor_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] quotient_o;
  logic [7:0] remainder_o;
  logic       div_zero_o;

  int total = 0;
  int bad   = 0;

  seq_div #(.width_p(8)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present operands on a falling edge; returns at the first falling edge after accept.
  task automatic start_op(input logic s, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk_i);
    chk("rdy_idle", ready_o, 1);
    valid_i    = 1'b1;
    signed_i   = s;
    dividend_i = a;
    divisor_i  = b;
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("rdy_busy", ready_o, 0);
  endtask

  // Called at the first falling edge after accept; n counts cycles since accept.
  task automatic wait_valid(output int n);
    n = 1;
    while (!valid_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    chk("valid_seen", valid_o, 1);
  endtask

  task automatic take_result();
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    chk("valid_drop", valid_o, 0);
    chk("rdy_back", ready_o, 1);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ez);
    int lat;
    start_op(s, a, b);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, 10);
    chk({tag, "_q"}, quotient_o, eq);
    chk({tag, "_r"}, remainder_o, er);
    chk({tag, "_z"}, div_zero_o, ez);
    $display("op %s s=%0d %02h/%02h -> q=%02h r=%02h z=%0d lat=%0d",
             tag, s, a, b, quotient_o, remainder_o, div_zero_o, lat);
    take_result();
  endtask

  initial begin
    int lat;
    reset_i    = 1'b1;
    valid_i    = 1'b0;
    ready_i    = 1'b0;
    signed_i   = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_q", quotient_o, 0);
    chk("rst_r", remainder_o, 0);
    chk("rst_z", div_zero_o, 0);

    run_op("u200d3",   1'b0, 8'd200, 8'd3,  8'h42, 8'h02, 1'b0);
    run_op("sm100d7",  1'b1, 8'h9C,  8'h07, 8'hF2, 8'hFE, 1'b0);
    run_op("s100dm7",  1'b1, 8'h64,  8'hF9, 8'hF2, 8'h02, 1'b0);
    run_op("u13d0",    1'b0, 8'h0D,  8'h00, 8'hFF, 8'h0D, 1'b1);
    run_op("s13d0",    1'b1, 8'h0D,  8'h00, 8'hFF, 8'h0D, 1'b1);
    run_op("s80dff",   1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0);
    run_op("u80dff",   1'b0, 8'h80,  8'hFF, 8'h00, 8'h80, 1'b0);
    run_op("u255d16",  1'b0, 8'hFF,  8'h10, 8'h0F, 8'h0F, 1'b0);

    // Backpressure with a competing request held on the operand port.
    start_op(1'b0, 8'd9, 8'd2);
    wait_valid(lat);
    chk("bp_lat", lat, 10);
    valid_i    = 1'b1;
    dividend_i = 8'd20;
    divisor_i  = 8'd3;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", valid_o, 1);
      chk("bp_ready", ready_o, 0);
      chk("bp_q", quotient_o, 8'd4);
      chk("bp_r", remainder_o, 8'd1);
      $display("bp hold cycle %0d valid=%0d ready=%0d q=%02h r=%02h",
               i, valid_o, ready_o, quotient_o, remainder_o);
      @(negedge clk_i);
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    chk("bp_hs_valid", valid_o, 0);
    chk("bp_hs_ready", ready_o, 1);
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("bp_accepted", ready_o, 0);
    wait_valid(lat);
    chk("bp2_lat", lat, 10);
    chk("bp2_q", quotient_o, 8'd6);
    chk("bp2_r", remainder_o, 8'd2);
    $display("op bp2 20/3 -> q=%02h r=%02h lat=%0d", quotient_o, remainder_o, lat);
    take_result();

    // Reset during the 4th CALC cycle.
    start_op(1'b0, 8'd200, 8'd3);
    repeat (3) @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    chk("mr_ready", ready_o, 1);
    chk("mr_valid", valid_o, 0);
    chk("mr_q", quotient_o, 0);
    chk("mr_r", remainder_o, 0);
    chk("mr_z", div_zero_o, 0);
    $display("mid-op reset ready=%0d valid=%0d q=%02h r=%02h", ready_o, valid_o, quotient_o, remainder_o);
    run_op("u9d2", 1'b0, 8'd9, 8'd2, 8'd4, 8'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
